// File: rtl/sdp_arbiter_if.sv
// Request/response bundle between two requesters and the shared arithmetic pipeline.
// Requester i occupies bit i of each 2-bit field and lane [i*WIDTH +: WIDTH] of each operand bus.
interface sdp_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_ctl_1;
    logic [1:0]         req_ctl_2;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*WIDTH-1:0] req_c;
    logic               resp_valid;
    logic               resp_id;
    logic [WIDTH-1:0]   resp_data;
    logic               busy;

    modport master (
        output req_valid, req_ctl_1, req_ctl_2, req_a, req_b, req_c,
        input  req_ready, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_ctl_1, req_ctl_2, req_a, req_b, req_c,
        output req_ready, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/sdp_arbiter.sv
// Two-requester arbiter feeding a 3-stage (a +/- b) +/- c pipeline; SDP_ARB_RR_EN selects round-robin, else requester 0 has fixed priority.
// Latency: an operation accepted in cycle T responds in cycle T+3; one accept per cycle.
// Backpressure: none downstream; the pipeline never stalls and req_ready only arbitrates between requesters.
module sdp_arbiter #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    sdp_arbiter_if.slave bus
);
    typedef struct packed {
        logic             id;
        logic             ctl_1;
        logic             ctl_2;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } s1_t;

    typedef struct packed {
        logic             id;
        logic             ctl_2;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] c;
    } s2_t;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] n;
    } s3_t;

    logic       prio;   // 0: requester 0 wins a tie, 1: requester 1 wins
    logic [1:0] grant;
    logic       acc;
    logic       acc_id;

    logic s1_vld, s2_vld, s3_vld;
    s1_t  s1_q;
    s2_t  s2_q;
    s3_t  s3_q;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (bus.req_valid == 2'b11)
                grant = prio ? 2'b10 : 2'b01;
            else
                grant = bus.req_valid;
        end
    end

    assign acc    = |grant;
    assign acc_id = grant[1];
    assign bus.req_ready = grant;

`ifdef SDP_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            prio <= 1'b0;
        else if (acc)
            prio <= ~acc_id;
    end
`else
    assign prio = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
        end else begin
            s1_vld <= acc;
            if (acc) begin
                s1_q.id    <= acc_id;
                s1_q.ctl_1 <= bus.req_ctl_1[acc_id];
                s1_q.ctl_2 <= bus.req_ctl_2[acc_id];
                s1_q.a     <= acc_id ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
                s1_q.b     <= acc_id ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
                s1_q.c     <= acc_id ? bus.req_c[WIDTH +: WIDTH] : bus.req_c[0 +: WIDTH];
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_q.id    <= s1_q.id;
                s2_q.ctl_2 <= s1_q.ctl_2;
                s2_q.m     <= s1_q.ctl_1 ? (s1_q.a + s1_q.b) : (s1_q.a - s1_q.b);
                s2_q.c     <= s1_q.c;
            end

            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_q.id <= s2_q.id;
                s3_q.n  <= s2_q.ctl_2 ? (s2_q.m + s2_q.c) : (s2_q.m - s2_q.c);
            end
        end
    end

    assign bus.resp_valid = s3_vld;
    assign bus.resp_id    = s3_q.id;
    assign bus.resp_data  = s3_q.n;
    assign bus.busy       = s1_vld | s2_vld | s3_vld;
endmodule

// File: tb/tb_sdp_arbiter.sv
// Directed bench for sdp_arbiter (WIDTH = 8); expectations are hand-computed per cycle window.
// Compile with SDP_ARB_RR_EN defined to check the round-robin build.
module tb_sdp_arbiter;
    localparam int W   = 8;
    localparam int MAXW = 8;

    typedef struct packed {
        logic         c1;
        logic         c2;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sdp_arbiter_if #(.WIDTH(W)) bif ();

    sdp_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus and expectations for one window.
    logic [1:0]   vv      [MAXW];
    op_t          op0     [MAXW];
    op_t          op1     [MAXW];
    logic [1:0]   rdy_exp [MAXW];
    logic         rv_exp  [MAXW];
    logic         id_exp  [MAXW];
    logic [W-1:0] d_exp   [MAXW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_win();
        for (int k = 0; k < MAXW; k++) begin
            vv[k]      = 2'b00;
            op0[k]     = '0;
            op1[k]     = '0;
            rdy_exp[k] = 2'b00;
            rv_exp[k]  = 1'b0;
            id_exp[k]  = 1'b0;
            d_exp[k]   = '0;
        end
    endtask

    task automatic apply(input logic [1:0] v, input op_t o0, input op_t o1);
        bif.req_valid = v;
        bif.req_ctl_1 = {o1.c1, o0.c1};
        bif.req_ctl_2 = {o1.c2, o0.c2};
        bif.req_a     = {o1.a, o0.a};
        bif.req_b     = {o1.b, o0.b};
        bif.req_c     = {o1.c, o0.c};
    endtask

    task automatic run_window(input string tag, input int n);
        logic bexp;
        for (int k = 0; k < n; k++) begin
            apply(vv[k], op0[k], op1[k]);
            #1;
            bexp = 1'b0;
            for (int j = 1; j <= 3; j++)
                if (k - j >= 0 && rdy_exp[k-j] != 2'b00) bexp = 1'b1;
            check($sformatf("%s[%0d].ready", tag, k), 32'(bif.req_ready), 32'(rdy_exp[k]));
            check($sformatf("%s[%0d].resp_valid", tag, k), 32'(bif.resp_valid), 32'(rv_exp[k]));
            check($sformatf("%s[%0d].busy", tag, k), 32'(bif.busy), 32'(bexp));
            if (rv_exp[k]) begin
                check($sformatf("%s[%0d].resp_id", tag, k), 32'(bif.resp_id), 32'(id_exp[k]));
                check($sformatf("%s[%0d].resp_data", tag, k), 32'(bif.resp_data), 32'(d_exp[k]));
            end
            step();
        end
        apply(2'b00, '0, '0);
    endtask

    initial begin
        apply(2'b00, '0, '0);

        // Reset: ready must stay low even with both requesting.
        reset = 1'b1;
        step();
        apply(2'b11, '0, '0);
        #1;
        check("rst.ready", 32'(bif.req_ready), 32'd0);
        step();
        reset = 1'b0;
        apply(2'b00, '0, '0);
        #1;
        check("rst.resp_valid", 32'(bif.resp_valid), 32'd0);
        check("rst.resp_id", 32'(bif.resp_id), 32'd0);
        check("rst.resp_data", 32'(bif.resp_data), 32'd0);
        check("rst.busy", 32'(bif.busy), 32'd0);

        // req0: (3+4)+5 = 12
        clear_win();
        vv[0] = 2'b01; op0[0] = '{1'b1, 1'b1, 8'd3, 8'd4, 8'd5}; rdy_exp[0] = 2'b01;
        rv_exp[3] = 1'b1; id_exp[3] = 1'b0; d_exp[3] = 8'd12;
        run_window("s1", 5);

        // req1: (2-5)-1 wraps to 0xFC
        clear_win();
        vv[0] = 2'b10; op1[0] = '{1'b0, 1'b0, 8'd2, 8'd5, 8'd1}; rdy_exp[0] = 2'b10;
        rv_exp[3] = 1'b1; id_exp[3] = 1'b1; d_exp[3] = 8'hFC;
        run_window("s2", 5);

        // Both requesting for 4 cycles: req0 -> 3, req1 -> 30.
        clear_win();
        for (int k = 0; k < 4; k++) begin
            vv[k]  = 2'b11;
            op0[k] = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd1};
            op1[k] = '{1'b1, 1'b1, 8'd10, 8'd10, 8'd10};
`ifdef SDP_ARB_RR_EN
            rdy_exp[k] = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            rdy_exp[k] = 2'b01;
`endif
            rv_exp[k+3] = 1'b1;
            id_exp[k+3] = rdy_exp[k][1];
            d_exp[k+3]  = rdy_exp[k][1] ? 8'h1E : 8'h03;
        end
        run_window("s3", 8);

        // Three consecutive accepts: 0x0E, 0x0A, 0xFE.
        clear_win();
        vv[0] = 2'b01; op0[0] = '{1'b1, 1'b0, 8'd7, 8'd8, 8'd1}; rdy_exp[0] = 2'b01;
        vv[1] = 2'b10; op1[1] = '{1'b0, 1'b1, 8'd9, 8'd3, 8'd4}; rdy_exp[1] = 2'b10;
        vv[2] = 2'b01; op0[2] = '{1'b0, 1'b0, 8'd0, 8'd1, 8'd1}; rdy_exp[2] = 2'b01;
        rv_exp[3] = 1'b1; id_exp[3] = 1'b0; d_exp[3] = 8'h0E;
        rv_exp[4] = 1'b1; id_exp[4] = 1'b1; d_exp[4] = 8'h0A;
        rv_exp[5] = 1'b1; id_exp[5] = 1'b0; d_exp[5] = 8'hFE;
        run_window("s4", 7);

        // Reset one cycle after an accept discards the operation.
        apply(2'b01, '{1'b1, 1'b1, 8'd1, 8'd2, 8'd3}, '0);
        #1;
        check("s5.accept_ready", 32'(bif.req_ready), 32'h1);
        step();
        reset = 1'b1;
        apply(2'b11, '0, '0);
        #1;
        check("s5.ready_in_reset", 32'(bif.req_ready), 32'h0);
        check("s5.busy_inflight", 32'(bif.busy), 32'h1);
        step();
        reset = 1'b0;
        apply(2'b00, '0, '0);
        #1;
        check("s5.resp_valid", 32'(bif.resp_valid), 32'h0);
        check("s5.resp_id", 32'(bif.resp_id), 32'h0);
        check("s5.resp_data", 32'(bif.resp_data), 32'h0);
        check("s5.busy", 32'(bif.busy), 32'h0);
        clear_win();
        run_window("s5q", 5);

        // req0, idle, req1: 3 then 8, no response in idle slots.
        clear_win();
        vv[0] = 2'b01; op0[0] = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd1}; rdy_exp[0] = 2'b01;
        vv[2] = 2'b10; op1[2] = '{1'b1, 1'b0, 8'd5, 8'd5, 8'd2}; rdy_exp[2] = 2'b10;
        rv_exp[3] = 1'b1; id_exp[3] = 1'b0; d_exp[3] = 8'd3;
        rv_exp[5] = 1'b1; id_exp[5] = 1'b1; d_exp[5] = 8'd8;
        run_window("s6", 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdp_arbiter.md
SDP_ARBITER -- requirements
Module: sdp_arbiter

Interface
REQ-001 Parameter WIDTH SHALL be declared with default 8; it sets the width of the operands and the result.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_valid  input  2  bit i set: requester i presents an operation.
REQ-005 req_ready  output  2  bit i set: requester i is granted this cycle (one-hot or zero).
REQ-006 req_ctl_1  input  2  bit i: requester i stage-1 select (1 = a+b, 0 = a-b).
REQ-007 req_ctl_2  input  2  bit i: requester i stage-2 select (1 = m+c, 0 = m-c).
REQ-008 req_a  input  2*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  2*WIDTH  operand b; same packing as req_a.
REQ-010 req_c  input  2*WIDTH  operand c; same packing as req_a.
REQ-011 resp_valid  output  1  result is valid this cycle (single-cycle pulse, no backpressure).
REQ-012 resp_id  output  1  index of the requester that owns the result.
REQ-013 resp_data  output  WIDTH  result value.
REQ-014 busy  output  1  at least one pipeline stage holds a valid operation.

Function
REQ-015 An operation SHALL be accepted in any cycle where req_valid[i] and req_ready[i] are both high; at most one operation is accepted per cycle.
REQ-016 req_ready SHALL be combinational from req_valid and the priority state; a requester with req_valid[i] = 0 SHALL never see req_ready[i] = 1.
REQ-017 Arbitration SHALL grant the single requesting requester; when both request, the requester named by the priority state wins.
REQ-018 The datapath SHALL be three registered stages. S1 captures ctl_1, ctl_2, a, b, c, id and valid. S2 computes m = ctl_1 ? a+b : a-b and carries ctl_2, c, id and valid. S3 computes n = ctl_2 ? m+c : m-c and carries id and valid.
REQ-019 All arithmetic SHALL be modulo 2^WIDTH; carries and borrows are discarded.
REQ-020 An operation accepted in cycle T SHALL drive resp_valid = 1, resp_id and resp_data = n in cycle T+3.
REQ-021 The pipeline SHALL never stall; back-to-back accepts yield back-to-back responses in acceptance order.
REQ-022 Stages holding no valid operation SHALL not assert resp_valid; resp_data is don't-care when resp_valid = 0.
REQ-023 busy SHALL equal the OR of the S1, S2 and S3 valid bits.

Reset
REQ-024 While reset = 1 at a posedge, all stage valid bits, data registers, id bits and the priority state SHALL clear to 0.
REQ-025 After reset: resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0, and priority favours requester 0.
REQ-026 Reset asserted with operations in flight SHALL discard them; no response for those operations ever appears.
REQ-027 req_ready SHALL be 2'b00 in any cycle where reset = 1.

Configuration
REQ-028 Macro SDP_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With SDP_ARB_RR_EN defined: round-robin. After a grant to requester i, priority passes to requester 1-i. With no grant, priority is held.
REQ-030 Without SDP_ARB_RR_EN: fixed priority, with requester 0 always winning. The priority state is absent or tied to 0.

Verification
REQ-031 Bench SHALL cover each scenario below with WIDTH = 8.
- Reset, then req0: ctl_1=1, ctl_2=1, a=3, b=4, c=5 -> 3 cycles later resp_valid=1, resp_id=0, resp_data=12; busy high for exactly the 3 cycles after accept.
- req1: ctl_1=0, ctl_2=0, a=2, b=5, c=1 -> resp_data=8'hFC (wrap), resp_id=1.
- Both requesting continuously for 4 cycles, RR build -> grants 0,1,0,1 and responses in the same order; fixed build -> grants 0,0,0,0 and req_ready[1] stays 0.
- Accepts on 3 consecutive cycles -> resp_valid high on 3 consecutive cycles, data and id in issue order.
- Reset asserted 1 cycle after an accept -> no resp_valid ever appears for it; all outputs are 0 in the following cycle.
- Single-requester alternation, req0 then idle then req1 -> each granted immediately; no spurious resp_valid in idle slots.
